// File: rtl/sys_array_ctrl_display.sv
// Board-level sequencer for the systolic-array fetcher: key sync, load/compute FSM with
// ready timeout, captured result buffer, per-row argmax and a registered display mux.
//
//  state    | meaning
//  IDLE     | waiting for a key press
//  LOAD     | one-cycle weights-load pulse, params become valid
//  START    | one-cycle start-compute pulse
//  WAIT_RDY | waiting for fetch_ready, bounded by TIMEOUT
//  CAPTURE  | latch fetcher results into the buffer
//  ARGMAX   | one element per cycle, class index per row
//  DONE     | results and classes valid
//  ERROR    | ready timed out, only a load press leaves
module sys_array_ctrl_display #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_A_W  = 1,
    parameter int ARRAY_W_L  = 10,
    parameter int SEL_W      = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   key_load_n,
    input  logic                   key_start_n,
    input  logic                   key_mode_n,
    input  logic [SEL_W-1:0]       row_sel,
    input  logic [SEL_W-1:0]       col_sel,
    output logic                   fetch_weights_load,
    output logic                   fetch_start_comp,
    input  logic                   fetch_ready,
    input  logic [0:ARRAY_A_W-1][0:ARRAY_W_L-1][2*DATA_WIDTH-1:0] fetch_out_data,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   mode,
    output logic                   sel_err,
    output logic [2*DATA_WIDTH-1:0] disp_value
);
    localparam int DW2   = 2 * DATA_WIDTH;
    localparam int AR_W  = (ARRAY_A_W > 1) ? $clog2(ARRAY_A_W) : 1;
    localparam int AC_W  = (ARRAY_W_L > 1) ? $clog2(ARRAY_W_L) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [AR_W-1:0]  ROW_LAST = AR_W'(ARRAY_A_W - 1);
    localparam logic [AC_W-1:0]  COL_LAST = AC_W'(ARRAY_W_L - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT_RDY, S_CAPTURE, S_ARGMAX, S_DONE, S_ERROR
    } state_t;

    state_t state_q, state_d;
    logic [2:0] ks1_q, ks1_d, ks2_q, ks2_d, ks3_q, ks3_d;
    logic pv_q, pv_d, err_q, err_d, mode_q, mode_d, sel_err_q, sel_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [0:ARRAY_A_W-1][0:ARRAY_W_L-1][DW2-1:0] res_q, res_d;
    logic [0:ARRAY_A_W-1][AC_W-1:0] cls_q, cls_d;
    logic [AR_W-1:0] ar_q, ar_d;
    logic [AC_W-1:0] ac_q, ac_d, bidx_q, bidx_d;
    logic signed [DW2-1:0] best_q, best_d, elem;
    logic [DW2-1:0] disp_q, disp_d, raw_sel;
    logic [AC_W-1:0] cls_sel;
    logic [2:0] press;
    logic load_p, start_p, mode_p, take, row_oob, col_oob;

    // Bit 0 load, bit 1 start, bit 2 mode; a press is the high-to-low step after the synchroniser.
    assign press   = ks3_q & ~ks2_q;
    assign load_p  = press[0];
    assign start_p = press[1];
    assign mode_p  = press[2];

    always_comb begin
        ks1_d   = {key_mode_n, key_start_n, key_load_n};
        ks2_d   = ks1_q;
        ks3_d   = ks2_q;
        state_d = state_q;
        pv_d    = pv_q;
        err_d   = err_q;
        mode_d  = mode_q ^ mode_p;
        cnt_d   = cnt_q;
        res_d   = res_q;
        cls_d   = cls_q;
        ar_d    = ar_q;
        ac_d    = ac_q;
        best_d  = best_q;
        bidx_d  = bidx_q;
        elem    = '0;
        for (int r = 0; r < ARRAY_A_W; r++)
            for (int c = 0; c < ARRAY_W_L; c++)
                if (ar_q == AR_W'(r) && ac_q == AC_W'(c)) elem = res_q[r][c];
        // First column seeds the running max; strict compare keeps the lowest index on ties.
        take = (ac_q == '0) || (elem > best_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (load_p) state_d = S_LOAD;
                else if (start_p && pv_q) state_d = S_START;
            end
            S_LOAD: begin
                pv_d    = 1'b1;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (cnt_q != '0 && fetch_ready) begin
                    state_d = S_CAPTURE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                res_d   = fetch_out_data;
                ar_d    = '0;
                ac_d    = '0;
                state_d = S_ARGMAX;
            end
            S_ARGMAX: begin
                if (take) begin
                    best_d = elem;
                    bidx_d = ac_q;
                end
                if (ac_q == COL_LAST) begin
                    for (int r = 0; r < ARRAY_A_W; r++)
                        if (ar_q == AR_W'(r)) cls_d[r] = take ? ac_q : bidx_q;
                    ac_d = '0;
                    if (ar_q == ROW_LAST) state_d = S_DONE;
                    else ar_d = ar_q + 1'b1;
                end else begin
                    ac_d = ac_q + 1'b1;
                end
            end
            S_ERROR: begin
                if (load_p) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        raw_sel = '0;
        cls_sel = '0;
        for (int r = 0; r < ARRAY_A_W; r++) begin
            if (row_sel == SEL_W'(r)) cls_sel = cls_q[r];
            for (int c = 0; c < ARRAY_W_L; c++)
                if (row_sel == SEL_W'(r) && col_sel == SEL_W'(c)) raw_sel = res_q[r][c];
        end
        row_oob   = 32'(row_sel) >= ARRAY_A_W;
        col_oob   = 32'(col_sel) >= ARRAY_W_L;
        sel_err_d = row_oob | (~mode_q & col_oob);
        if (sel_err_d)   disp_d = '0;
        else if (mode_q) disp_d = DW2'(cls_sel);
        else             disp_d = raw_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ks1_q     <= 3'b111;
            ks2_q     <= 3'b111;
            ks3_q     <= 3'b111;
            pv_q      <= 1'b0;
            err_q     <= 1'b0;
            mode_q    <= 1'b0;
            sel_err_q <= 1'b0;
            cnt_q     <= '0;
            res_q     <= '0;
            cls_q     <= '0;
            ar_q      <= '0;
            ac_q      <= '0;
            best_q    <= '0;
            bidx_q    <= '0;
            disp_q    <= '0;
        end else begin
            state_q   <= state_d;
            ks1_q     <= ks1_d;
            ks2_q     <= ks2_d;
            ks3_q     <= ks3_d;
            pv_q      <= pv_d;
            err_q     <= err_d;
            mode_q    <= mode_d;
            sel_err_q <= sel_err_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            cls_q     <= cls_d;
            ar_q      <= ar_d;
            ac_q      <= ac_d;
            best_q    <= best_d;
            bidx_q    <= bidx_d;
            disp_q    <= disp_d;
        end
    end

    // Pulses are gated by reset so nothing reaches the fetcher in the reset cycle.
    assign fetch_weights_load = (state_q == S_LOAD) && !reset;
    assign fetch_start_comp   = (state_q == S_START) && !reset;
    assign busy       = (state_q == S_LOAD) || (state_q == S_START) || (state_q == S_WAIT_RDY)
                     || (state_q == S_CAPTURE) || (state_q == S_ARGMAX);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign mode       = mode_q;
    assign sel_err    = sel_err_q;
    assign disp_value = disp_q;
endmodule

// File: doc/sys_array_ctrl_display.md
Name: sys_array_ctrl_display

Overview:
- Next-generation board-level controller for the systolic-array fetcher.
- Replaces the raw button-inverting wrapper logic with:
  - synchronised, edge-detected button handling;
  - a load/compute sequencing FSM with a ready timeout;
  - a registered result buffer;
  - a selectable display mode: raw element, or per-row argmax class index (MNIST 784x10 use).
- Sits between the board keys/switches, the fetcher handshake and the top-level seg7_tohex instances.

Parameters:
- DATA_WIDTH, 8, operand width; results are 2*DATA_WIDTH signed.
- ARRAY_A_W, 1, result rows.
- ARRAY_W_L, 10, result columns (classes).
- SEL_W, 4, width of row_sel/col_sel.
- TIMEOUT, 65535, max cycles to wait for fetch_ready after start before declaring error.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- key_load_n  in  1  board key, active-low, asynchronous to clk
- key_start_n  in  1  board key, active-low, asynchronous to clk
- key_mode_n  in  1  board key, active-low; toggles display mode
- row_sel  in  SEL_W  display row index
- col_sel  in  SEL_W  display column index (mode 0 only)
- fetch_weights_load  out  1  one-cycle high pulse to fetcher
- fetch_start_comp  out  1  one-cycle high pulse to fetcher
- fetch_ready  in  1  fetcher results-valid level
- fetch_out_data  in  [0:ARRAY_A_W-1][0:ARRAY_W_L-1][2*DATA_WIDTH-1:0]  fetcher results, signed
- busy  out  1  high in LOAD, START, WAIT_RDY, CAPTURE, ARGMAX
- done  out  1  high in DONE
- err  out  1  sticky timeout flag
- mode  out  1  0 = raw element, 1 = class index
- sel_err  out  1  row_sel/col_sel out of range
- disp_value  out  2*DATA_WIDTH  value for the hex converters

Behaviour:
- Reset state: IDLE, params_valid=0, mode=0, result buffer and class registers 0. All outputs are 0 the cycle after reset is sampled.
- Keys: two-flop synchroniser per key, then falling-edge detect yields a one-cycle press pulse. A held key produces exactly one pulse. No debounce; the bench drives clean edges.
- FSM states: IDLE, LOAD, START, WAIT_RDY, CAPTURE, ARGMAX, DONE, ERROR.
- Load press:
  - From IDLE, DONE or ERROR: go to LOAD.
  - LOAD asserts fetch_weights_load for exactly 1 cycle, sets params_valid=1, clears err, then returns to IDLE.
  - Ignored while busy.
- Start press:
  - From IDLE or DONE with params_valid=1: go to START.
  - START asserts fetch_start_comp for 1 cycle, then enters WAIT_RDY.
  - Ignored if params_valid=0, busy, or in ERROR.
- Simultaneous load and start press: load wins; start is dropped.
- WAIT_RDY:
  - fetch_ready is ignored in the first WAIT_RDY cycle, so stale ready is rejected.
  - Thereafter, fetch_ready=1 moves to CAPTURE.
  - A cycle counter runs from 0; reaching TIMEOUT moves to ERROR with err=1.
- CAPTURE: one cycle; latch the whole fetch_out_data into the result buffer.
- ARGMAX:
  - Sequential scan over r=0..ARRAY_A_W-1, c=0..ARRAY_W_L-1, one element per cycle, so ARRAY_A_W*ARRAY_W_L cycles.
  - Comparison is signed.
  - Strict greater-than, so ties resolve to the lowest index.
  - class[r] is written after column ARRAY_W_L-1 of row r.
  - Then go to DONE.
- Latency: start press to done is 2 (sync) + 1 (edge) + 1 (START) + N_ready + 1 (CAPTURE) + A_W*W_L cycles.
- DONE: a new start recomputes; the buffer is overwritten only at CAPTURE.
- ERROR: exited only by a load press or reset.
- Mode press: toggles mode in any state.
- Display (registered, 1-cycle latency from selects/buffer):
  - mode 0: disp_value = buf[row_sel][col_sel].
  - mode 1: disp_value = zero-extended class[row_sel].
  - sel_err=1 and disp_value=0 when row_sel >= ARRAY_A_W, or (mode 0 and col_sel >= ARRAY_W_L).
  - While busy, disp_value holds the previous buffer contents; the buffer is unchanged until CAPTURE.
- Reset mid-operation: synchronous; next edge gives IDLE with the full clear listed above. No fetch pulse is issued in the reset cycle.

Test Plan:
- Setup: ARRAY_A_W=2, ARRAY_W_L=4, behavioural fetcher model raises ready 5 cycles after start_comp.
- Reset, then start press with no prior load -> no fetch_start_comp pulse, state stays IDLE, busy=0.
- Load press held 20 cycles -> exactly one fetch_weights_load pulse. Then start press with outputs row0={3,-7,12,12}, row1={-1,-2,-3,-4}:
  - mode0 row=0 col=2 -> disp_value=12;
  - mode press, row=0 -> 2 (tie to lowest index);
  - row=1 -> 0;
  - done asserted at the computed latency.
- Out of range: row_sel=3 -> sel_err=1, disp_value=0. In mode 0, col_sel=5 -> sel_err=1.
- Fetcher never raises ready, TIMEOUT=100 -> err=1 in the cycle the counter reaches 100. A start press is then ignored; a load press clears err and returns to IDLE.
- Load and start pressed on the same edge from DONE -> only fetch_weights_load pulses.
- Assert reset during ARGMAX -> next cycle busy=0, done=0, mode=0, disp_value=0, and a following start requires a fresh load.
